// File: rtl/pixel_pack_if.sv
// pixel_pack_if: byte-in / RGB-triplet-out handshake bundle for pixel_pack
interface pixel_pack_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_rgb [3];
  logic       m_last;
  modport slave (input s_valid, s_data, s_last, m_ready, output s_ready, m_valid, m_rgb, m_last);
  modport master (output s_valid, s_data, s_last, m_ready, input s_ready, m_valid, m_rgb, m_last);
endinterface

// File: rtl/pixel_pack.sv
// pixel_pack: packs serial component bytes into RGB triplets with optional inversion and a triplet counter
module pixel_pack #(
  parameter bit INVERT = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pixel_pack_if.slave      bus,
  output logic             err_short,
  output logic [CNT_W-1:0] tri_count
);
  localparam logic [1:0] COLLECT0 = 2'd0, COLLECT1 = 2'd1, COLLECT2 = 2'd2;
  logic [1:0] idx;
  logic [7:0] stage [2];
  logic [7:0] val;
  logic       acc, done, xfer;
  assign val = INVERT ? 8'hFF - bus.s_data : bus.s_data;
  assign bus.s_ready = (idx != COLLECT2) || !bus.m_valid || bus.m_ready;
  assign acc = bus.s_valid && bus.s_ready;
  assign done = acc && idx == COLLECT2;
  assign xfer = bus.m_valid && bus.m_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= COLLECT0;
      stage[0] <= '0;
      stage[1] <= '0;
      bus.m_rgb[0] <= '0;
      bus.m_rgb[1] <= '0;
      bus.m_rgb[2] <= '0;
      bus.m_valid <= 1'b0;
      bus.m_last <= 1'b0;
      err_short <= 1'b0;
      tri_count <= '0;
    end else begin
      err_short <= acc && bus.s_last && idx != COLLECT2;
      bus.m_valid <= done || (bus.m_valid && !bus.m_ready);
      if (acc) idx <= (idx == COLLECT2 || bus.s_last) ? COLLECT0 : idx + 2'd1;
      if (acc && idx == COLLECT0) stage[0] <= val;
      if (acc && idx == COLLECT1) stage[1] <= val;
      if (done) begin
        bus.m_rgb[0] <= stage[0];
        bus.m_rgb[1] <= stage[1];
        bus.m_rgb[2] <= val;
        bus.m_last <= bus.s_last;
      end
      if (xfer) tri_count <= tri_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pixel_pack.sv
// tb_pixel_pack: scoreboard bench driving an inverting and a pass-through/narrow-counter pixel_pack in lockstep
module tb_pixel_pack;
  logic clk = 1'b0, rst_n = 1'b0;
  logic s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic [7:0] s_data = '0;
  logic err_a, err_b;
  logic [15:0] tc_a;
  logic [1:0] tc_b;
  int n_chk = 0, n_pass = 0;
  typedef struct packed {logic [7:0] c0, c1, c2; logic last;} trip_t;
  trip_t sb [$];
  trip_t t;
  logic [1:0] midx = 2'd0;
  logic mv = 1'b0, err_p = 1'b0, er, acc;
  logic [7:0] st0 = '0, st1 = '0;
  logic [15:0] cnt_a = '0;
  logic [1:0] cnt_b = '0;
  pixel_pack_if a ();
  pixel_pack_if b ();
  assign a.s_valid = s_valid;
  assign a.s_data = s_data;
  assign a.s_last = s_last;
  assign a.m_ready = m_ready;
  assign b.s_valid = s_valid;
  assign b.s_data = s_data;
  assign b.s_last = s_last;
  assign b.m_ready = m_ready;
  pixel_pack #(.INVERT(1'b1), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave), .err_short(err_a), .tri_count(tc_a));
  pixel_pack #(.INVERT(1'b0), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave), .err_short(err_b), .tri_count(tc_b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      midx = 2'd0;
      mv = 1'b0;
      err_p = 1'b0;
      cnt_a = '0;
      cnt_b = '0;
      sb.delete();
      chk("rst_ready", 32'(a.s_ready), 1);
      chk("rst_valid", 32'(a.m_valid | b.m_valid), 0);
      chk("rst_last", 32'(a.m_last), 0);
      chk("rst_rgb", {8'h0, a.m_rgb[0], a.m_rgb[1], a.m_rgb[2]}, 0);
      chk("rst_err", 32'(err_a | err_b), 0);
      chk("rst_cnt", 32'(tc_a) + 32'(tc_b), 0);
    end else begin
      er = midx != 2'd2 || !mv || m_ready;
      chk("s_ready_a", 32'(a.s_ready), 32'(er));
      chk("s_ready_b", 32'(b.s_ready), 32'(er));
      chk("m_valid_a", 32'(a.m_valid), 32'(mv));
      chk("m_valid_b", 32'(b.m_valid), 32'(mv));
      chk("err_a", 32'(err_a), 32'(err_p));
      chk("err_b", 32'(err_b), 32'(err_p));
      chk("cnt_a", 32'(tc_a), 32'(cnt_a));
      chk("cnt_b", 32'(tc_b), 32'(cnt_b));
      if (mv && m_ready) begin
        if (sb.size() == 0) chk("sb_empty", 0, 1);
        else begin
          t = sb.pop_front();
          chk("rgb_a", {8'h0, a.m_rgb[0], a.m_rgb[1], a.m_rgb[2]}, {8'h0, 8'hFF - t.c0, 8'hFF - t.c1, 8'hFF - t.c2});
          chk("rgb_b", {8'h0, b.m_rgb[0], b.m_rgb[1], b.m_rgb[2]}, {8'h0, t.c0, t.c1, t.c2});
          chk("last_a", 32'(a.m_last), 32'(t.last));
          chk("last_b", 32'(b.m_last), 32'(t.last));
        end
        cnt_a = cnt_a + 16'd1;
        cnt_b = cnt_b + 2'd1;
      end
      acc = s_valid && er;
      err_p = acc && s_last && midx != 2'd2;
      mv = (acc && midx == 2'd2) || (mv && !m_ready);
      if (acc) begin
        if (midx == 2'd0) st0 = s_data;
        if (midx == 2'd1) st1 = s_data;
        if (midx == 2'd2) sb.push_back({st0, st1, s_data, s_last});
        midx = (midx == 2'd2 || s_last) ? 2'd0 : midx + 2'd1;
      end
    end
  end
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (a.s_ready) break;
    end
    if (n == 60) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 s_valid = 1'b0;
    s_last = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    idle(3);
    rst_n = 1'b1;
    send(8'h00, 0);
    send(8'h10, 0);
    send(8'hFF, 1);
    idle(3);
    m_ready = 1'b0;
    fork
      for (int i = 0; i < 6; i++) send(8'h20 + 8'(i), i == 5);
      begin
        idle(12);
        m_ready = 1'b1;
      end
    join
    idle(3);
    send(8'h01, 0);
    send(8'h02, 1);
    send(8'h05, 0);
    send(8'h06, 0);
    send(8'h07, 1);
    idle(2);
    send(8'h12, 0);
    send(8'h34, 0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    send(8'hAA, 0);
    send(8'hBB, 0);
    send(8'hCC, 1);
    idle(2);
    chk("tc_a_after_rst", 32'(tc_a), 1);
    chk("tc_b_after_rst", 32'(tc_b), 1);
    for (int i = 0; i < 300; i++) send(8'($urandom), i % 3 == 2);
    idle(2);
    chk("tc_a_300", 32'(tc_a), 101);
    chk("tc_b_300", 32'(tc_b), 101 % 4);
    fork
      for (int i = 0; i < 200; i++) send(8'($urandom), $urandom_range(0, 5) == 0);
      begin
        repeat (900) begin
          @(posedge clk);
          #2 m_ready = $urandom_range(0, 2) != 0;
        end
      end
    join_any
    disable fork;
    #1 m_ready = 1'b1;
    idle(6);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pixel_pack.md
PIXEL_PACK -- requirements
Module: pixel_pack

Interface
REQ-001 Parameter: INVERT, default 1, meaning 1 = each stored component is 255 - s_data and 0 = s_data stored unchanged.
REQ-002 Parameter: CNT_W, default 16, meaning width of the completed-triplet counter.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 s_valid  input  1  upstream byte valid.
REQ-006 s_ready  output  1  block accepts byte this cycle.
REQ-007 s_data  input  8  serial pixel component byte, order component 0, 1, 2.
REQ-008 s_last  input  1  byte is final byte of packet.
REQ-009 m_valid  output  1  m_rgb holds a complete triplet.
REQ-010 m_ready  input  1  downstream accepts triplet.
REQ-011 m_rgb  output  8 x [2:0] unpacked array  assembled components; index i = i-th byte of triplet.
REQ-012 m_last  output  1  triplet ended its packet.
REQ-013 err_short  output  1  one-cycle pulse: packet ended on partial triplet.
REQ-014 tri_count  output  CNT_W  completed triplets emitted since reset.

Function
REQ-015 Byte transfer SHALL occur when s_valid && s_ready at posedge clk; triplet transfer SHALL occur when m_valid && m_ready.
REQ-016 Component index idx (0..2) SHALL select the destination of each accepted byte; idx SHALL advance by 1 per accepted byte and wrap 2 -> 0.
REQ-017 Bytes at idx 0 and 1 SHALL go to staging registers; the byte at idx 2 SHALL complete the triplet, loading m_rgb[0..2] from staging plus the current byte in the same edge.
REQ-018 Stored value SHALL be 8-bit 255 - s_data when INVERT=1 (no overflow possible), else s_data.
REQ-019 s_ready SHALL equal (idx != 2) || !m_valid || m_ready, combinationally; bytes 0 and 1 of the next triplet are accepted while the output is stalled.
REQ-020 m_valid SHALL set on the edge the triplet completes, clear on a triplet transfer with no simultaneous completion, and stay set when a transfer and a completion coincide (back-to-back, one triplet per 3 bytes sustained).
REQ-021 m_rgb and m_last SHALL hold stable while m_valid && !m_ready.
REQ-022 Latency: m_valid SHALL be high the cycle after the idx-2 byte transfer.
REQ-023 m_last SHALL load the s_last value of the idx-2 byte.
REQ-024 s_last on an accepted byte at idx 0 or 1 SHALL discard the staged partial triplet, force idx to 0, and pulse err_short high for exactly the next cycle; m_valid/m_rgb SHALL be unaffected.
REQ-025 tri_count SHALL increment by 1 on each triplet transfer and wrap from 2^CNT_W-1 to 0.
REQ-026 States: COLLECT0, COLLECT1, COLLECT2 (idx), orthogonal to output flag m_valid (EMPTY/FULL); no other states.

Reset
REQ-027 While rst_n=0 (asynchronously on assertion): idx=0, staging=0, m_rgb all 0, m_valid=0, m_last=0, err_short=0, tri_count=0.
REQ-028 s_ready SHALL be 1 during and immediately after reset (idx=0).
REQ-029 Reset mid-triplet or with m_valid high SHALL drop all staged and held data; no triplet is emitted for it.
REQ-030 Operation SHALL resume on the first posedge clk after rst_n deasserts.

Verification
REQ-031 INVERT=1, m_ready=1, bytes 0x00,0x10,0xFF with last on third -> next cycle m_valid=1, m_rgb={0xFF,0xEF,0x00}, m_last=1, tri_count=1 the cycle after.
REQ-032 m_ready=0, send 6 bytes continuously -> s_ready low only at the 6th byte; m_rgb holds first triplet until m_ready=1, then second triplet appears next cycle with no byte lost.
REQ-033 Continuous s_valid, m_ready=1, 300 bytes -> 100 triplets, m_valid never drops between consecutive completions, tri_count=100.
REQ-034 s_last on second byte (0x01,0x02) -> err_short one-cycle pulse, no m_valid, next byte 0x05 lands in m_rgb[0].
REQ-035 INVERT=0, bytes 0x12,0x34 then rst_n low for 2 cycles, then 0xAA,0xBB,0xCC -> single triplet {0xAA,0xBB,0xCC}, tri_count=1.
REQ-036 CNT_W=2, 4 triplet transfers -> tri_count sequence 1,2,3,0.
